// File: rtl/bean_tracker.sv
// bean_tracker: live 40x30 bean bitmap with eat detection, score,
// remaining-bean count, level-clear flag and a registered per-pixel
// bean lookup for the display scan.
module bean_tracker #(
    parameter logic [1199:0] INIT_MAP = '0,
    parameter int            POINTS   = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          restart,
    input  logic          tick,
    input  logic [9:0]    px,
    input  logic [8:0]    py,
    input  logic [9:0]    qx,
    input  logic [8:0]    qy,
    output logic          isbean,
    output logic [1199:0] bmap,
    output logic [15:0]   score,
    output logic [10:0]   remaining,
    output logic          ready,
    output logic          eat_pulse,
    output logic          all_clear
);

    localparam int NUM_TILES = 1200;
    localparam int NUM_COLS  = 40;
    localparam int NUM_ROWS  = 30;
    localparam logic [10:0] LAST_IDX = 11'(NUM_TILES - 1);

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        PLAY  = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_reg;
    logic [1199:0]   bmap_reg;
    logic [15:0]     score_reg;
    logic [10:0]     remaining_reg;
    logic [10:0]     scan_idx_reg;
    logic            ready_reg;
    logic            eat_pulse_reg;
    logic            all_clear_reg;
    logic            isbean_reg;

    // Pac-Man tile decode (16x16 pixel tiles)
    logic [5:0]  p_col;
    logic [4:0]  p_row;
    logic        p_in_range;
    logic [10:0] p_idx;
    logic        p_hit;

    // Display query tile decode
    logic [5:0]  q_col;
    logic [4:0]  q_row;
    logic        q_in_range;
    logic [10:0] q_idx;

    // Counting and scoring arithmetic
    logic [10:0] count_sum;
    logic [16:0] score_sum;
    logic [15:0] score_next;

    assign p_col      = px[9:4];
    assign p_row      = py[8:4];
    assign p_in_range = (p_col < 6'(NUM_COLS)) && (p_row < 5'(NUM_ROWS));
    assign p_idx      = 11'(p_row) * 11'(NUM_COLS) + 11'(p_col);
    // Range check gates the lookup so an off-map column never aliases
    // onto a tile of the next row.
    assign p_hit      = p_in_range && bmap_reg[p_idx];

    assign q_col      = qx[9:4];
    assign q_row      = qy[8:4];
    assign q_in_range = (q_col < 6'(NUM_COLS)) && (q_row < 5'(NUM_ROWS));
    assign q_idx      = 11'(q_row) * 11'(NUM_COLS) + 11'(q_col);

    assign count_sum  = remaining_reg + {10'd0, bmap_reg[scan_idx_reg]};
    assign score_sum  = {1'b0, score_reg} + 17'(POINTS);
    assign score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];

    // Main controller: bitmap recount, eating, scoring and level state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= COUNT;
            bmap_reg      <= INIT_MAP;
            score_reg     <= 16'd0;
            remaining_reg <= 11'd0;
            scan_idx_reg  <= 11'd0;
            ready_reg     <= 1'b0;
            eat_pulse_reg <= 1'b0;
            all_clear_reg <= 1'b0;
        end else begin
            eat_pulse_reg <= 1'b0;
            if (restart) begin
                // Reload the level; score carries over and a coincident
                // tick is dropped.
                state_reg     <= COUNT;
                bmap_reg      <= INIT_MAP;
                remaining_reg <= 11'd0;
                scan_idx_reg  <= 11'd0;
                ready_reg     <= 1'b0;
                all_clear_reg <= 1'b0;
            end else begin
                case (state_reg)
                    COUNT: begin
                        remaining_reg <= count_sum;
                        if (scan_idx_reg == LAST_IDX) begin
                            scan_idx_reg <= 11'd0;
                            if (count_sum != 11'd0) begin
                                state_reg <= PLAY;
                                ready_reg <= 1'b1;
                            end else begin
                                state_reg     <= DONE;
                                all_clear_reg <= 1'b1;
                            end
                        end else begin
                            scan_idx_reg <= scan_idx_reg + 11'd1;
                        end
                    end
                    PLAY: begin
                        if (tick && p_hit) begin
                            bmap_reg[p_idx] <= 1'b0;
                            score_reg       <= score_next;
                            remaining_reg   <= remaining_reg - 11'd1;
                            eat_pulse_reg   <= 1'b1;
                            if (remaining_reg == 11'd1) begin
                                state_reg     <= DONE;
                                ready_reg     <= 1'b0;
                                all_clear_reg <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        // Parked until restart or reset
                        state_reg <= DONE;
                    end
                    default: begin
                        state_reg <= COUNT;
                    end
                endcase
            end
        end
    end

    // Registered bean lookup for the display scan position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isbean_reg <= 1'b0;
        end else begin
            isbean_reg <= q_in_range && bmap_reg[q_idx];
        end
    end

    assign isbean    = isbean_reg;
    assign bmap      = bmap_reg;
    assign score     = score_reg;
    assign remaining = remaining_reg;
    assign ready     = ready_reg;
    assign eat_pulse = eat_pulse_reg;
    assign all_clear = all_clear_reg;

endmodule

// File: tb/tb_bean_tracker.sv
// Directed testbench for bean_tracker with a three-bean map
// (bits 0, 41 and 1199).
module tb_bean_tracker;

    localparam logic [1199:0] MAP = (1200'd1 << 0) | (1200'd1 << 41) | (1200'd1 << 1199);

    logic          clk;
    logic          rst_n;
    logic          restart;
    logic          tick;
    logic [9:0]    px;
    logic [8:0]    py;
    logic [9:0]    qx;
    logic [8:0]    qy;
    logic          isbean;
    logic [1199:0] bmap;
    logic [15:0]   score;
    logic [10:0]   remaining;
    logic          ready;
    logic          eat_pulse;
    logic          all_clear;

    int checks = 0;
    int passed = 0;

    bean_tracker #(.INIT_MAP(MAP), .POINTS(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (restart),
        .tick      (tick),
        .px        (px),
        .py        (py),
        .qx        (qx),
        .qy        (qy),
        .isbean    (isbean),
        .bmap      (bmap),
        .score     (score),
        .remaining (remaining),
        .ready     (ready),
        .eat_pulse (eat_pulse),
        .all_clear (all_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One tick at (x,y), outputs sampled after the eat edge
    task automatic do_tick(input logic [9:0] x, input logic [8:0] y);
        px   = x;
        py   = y;
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    // Wait for ready with a bound; checks the COUNT length is exactly 1200
    task automatic wait_ready(input string name);
        int cycles;
        cycles = 0;
        while (!ready && cycles < 2000) begin
            step();
            cycles++;
        end
        checks++;
        if (cycles !== 1200) $display("FAIL %s count_cycles got %0d expected 1200", name, cycles);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; restart = 1'b0; tick = 1'b0;
        px = '0; py = '0; qx = '0; qy = '0;
        step(); step();
        checks++;
        if (bmap !== MAP) $display("FAIL reset_bmap got %h expected %h", bmap, MAP); else passed++;
        checks++;
        if (score !== 16'd0 || remaining !== 11'd0) $display("FAIL reset_counts got score=%0d rem=%0d expected 0/0", score, remaining); else passed++;
        checks++;
        if ({ready, eat_pulse, all_clear, isbean} !== 4'b0000) $display("FAIL reset_flags got %b expected 0000", {ready, eat_pulse, all_clear, isbean}); else passed++;
        rst_n = 1'b1;
        wait_ready("reset");
        checks++;
        if (remaining !== 11'd3 || score !== 16'd0) $display("FAIL reset_recount got rem=%0d score=%0d expected 3/0", remaining, score); else passed++;
    endtask

    task automatic test_query_range();
        // col 41 row 0 would alias bit 41 if the range check were missing
        qx = 10'd656; qy = 9'd0;
        step();
        checks++;
        if (isbean !== 1'b0) $display("FAIL query_alias got %b expected 0", isbean); else passed++;
        qx = 10'd700; qy = 9'd24;
        step();
        checks++;
        if (isbean !== 1'b0) $display("FAIL query_qx700 got %b expected 0", isbean); else passed++;
        qx = 10'd632; qy = 9'd472;
        step();
        checks++;
        if (isbean !== 1'b1) $display("FAIL query_1199 got %b expected 1", isbean); else passed++;
    endtask

    task automatic test_no_eat();
        do_tick(10'd650, 9'd8);
        checks++;
        if (bmap !== MAP || score !== 16'd0 || remaining !== 11'd3 || eat_pulse !== 1'b0)
            $display("FAIL tick_col40 got score=%0d rem=%0d eat=%b expected 0/3/0", score, remaining, eat_pulse);
        else passed++;
        do_tick(10'd656, 9'd0);
        checks++;
        if (bmap[41] !== 1'b1 || remaining !== 11'd3 || eat_pulse !== 1'b0)
            $display("FAIL tick_alias got bit41=%b rem=%0d eat=%b expected 1/3/0", bmap[41], remaining, eat_pulse);
        else passed++;
        do_tick(10'd100, 9'd100);
        checks++;
        if (bmap !== MAP || score !== 16'd0 || remaining !== 11'd3 || eat_pulse !== 1'b0)
            $display("FAIL tick_empty got score=%0d rem=%0d eat=%b expected 0/3/0", score, remaining, eat_pulse);
        else passed++;
    endtask

    task automatic test_eat();
        qx = 10'd24; qy = 9'd24;
        step();
        checks++;
        if (isbean !== 1'b1) $display("FAIL isbean_before got %b expected 1", isbean); else passed++;
        do_tick(10'd24, 9'd24);
        checks++;
        if (bmap[41] !== 1'b0 || score !== 16'd10 || remaining !== 11'd2 || eat_pulse !== 1'b1)
            $display("FAIL eat41 got bit=%b score=%0d rem=%0d eat=%b expected 0/10/2/1", bmap[41], score, remaining, eat_pulse);
        else passed++;
        step();
        checks++;
        if (eat_pulse !== 1'b0) $display("FAIL eat_pulse_width got %b expected 0", eat_pulse); else passed++;
        checks++;
        if (isbean !== 1'b0) $display("FAIL isbean_after got %b expected 0", isbean); else passed++;
        do_tick(10'd24, 9'd24);
        checks++;
        if (score !== 16'd10 || remaining !== 11'd2 || eat_pulse !== 1'b0)
            $display("FAIL repeat_tick got score=%0d rem=%0d eat=%b expected 10/2/0", score, remaining, eat_pulse);
        else passed++;
    endtask

    task automatic test_clear();
        do_tick(10'd8, 9'd8);
        checks++;
        if (bmap[0] !== 1'b0 || score !== 16'd20 || remaining !== 11'd1 || all_clear !== 1'b0 || ready !== 1'b1)
            $display("FAIL eat0 got score=%0d rem=%0d clr=%b rdy=%b expected 20/1/0/1", score, remaining, all_clear, ready);
        else passed++;
        do_tick(10'd632, 9'd472);
        checks++;
        if (bmap !== 1200'd0 || score !== 16'd30 || remaining !== 11'd0 || eat_pulse !== 1'b1 || all_clear !== 1'b1 || ready !== 1'b0)
            $display("FAIL eat1199 got score=%0d rem=%0d eat=%b clr=%b rdy=%b expected 30/0/1/1/0", score, remaining, eat_pulse, all_clear, ready);
        else passed++;
        do_tick(10'd8, 9'd8);
        checks++;
        if (score !== 16'd30 || remaining !== 11'd0 || eat_pulse !== 1'b0 || all_clear !== 1'b1)
            $display("FAIL done_ignore got score=%0d rem=%0d eat=%b clr=%b expected 30/0/0/1", score, remaining, eat_pulse, all_clear);
        else passed++;
    endtask

    task automatic test_restart_tick();
        restart = 1'b1;
        do_tick(10'd8, 9'd8);
        restart = 1'b0;
        checks++;
        if (eat_pulse !== 1'b0 || bmap !== MAP || score !== 16'd30)
            $display("FAIL restart_tick got eat=%b bit0=%b score=%0d expected 0/1/30", eat_pulse, bmap[0], score);
        else passed++;
        checks++;
        if (ready !== 1'b0 || all_clear !== 1'b0 || remaining !== 11'd0)
            $display("FAIL restart_state got rdy=%b clr=%b rem=%0d expected 0/0/0", ready, all_clear, remaining);
        else passed++;
        wait_ready("restart");
        checks++;
        if (remaining !== 11'd3 || score !== 16'd30) $display("FAIL restart_recount got rem=%0d score=%0d expected 3/30", remaining, score); else passed++;
    endtask

    task automatic test_back_to_back();
        px = 10'd24; py = 9'd24; tick = 1'b1;
        step();
        checks++;
        if (score !== 16'd40 || eat_pulse !== 1'b1) $display("FAIL b2b_first got score=%0d eat=%b expected 40/1", score, eat_pulse); else passed++;
        step();
        checks++;
        if (score !== 16'd40 || remaining !== 11'd2 || eat_pulse !== 1'b0) $display("FAIL b2b_same got score=%0d rem=%0d eat=%b expected 40/2/0", score, remaining, eat_pulse); else passed++;
        px = 10'd8; py = 9'd8;
        step();
        px = 10'd632; py = 9'd472;
        step();
        tick = 1'b0;
        checks++;
        if (score !== 16'd60 || remaining !== 11'd0 || eat_pulse !== 1'b1 || all_clear !== 1'b1)
            $display("FAIL b2b_clear got score=%0d rem=%0d eat=%b clr=%b expected 60/0/1/1", score, remaining, eat_pulse, all_clear);
        else passed++;
    endtask

    task automatic test_async_reset();
        restart = 1'b1;
        step();
        restart = 1'b0;
        repeat (10) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (score !== 16'd0 || remaining !== 11'd0 || bmap !== MAP || ready !== 1'b0 || all_clear !== 1'b0)
            $display("FAIL async_reset got score=%0d rem=%0d rdy=%b clr=%b expected 0/0/0/0", score, remaining, ready, all_clear);
        else passed++;
        step();
        rst_n = 1'b1;
        wait_ready("async_reset");
        checks++;
        if (remaining !== 11'd3) $display("FAIL async_recount got %0d expected 3", remaining); else passed++;
    endtask

    initial begin
        test_reset();
        test_query_range();
        test_no_eat();
        test_eat();
        test_clear();
        test_restart_tick();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
